// File: rtl/mod_dmem_responder.sv
// Data-memory responder: turns load/store request levels from the memory stage into
// system-bus transactions (8-beat line read, address+data write).
// Optional macro DMEM_LINE_BUFFER_EN adds a one-line read buffer that serves repeat
// loads to the same 64-byte line without touching the bus.
module mod_dmem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_reqFlag,
  input  logic [63:0] data_reqAddr,
  input  logic        store_reqFlag,
  input  logic [63:0] store_reqAddr,
  input  logic [63:0] store_data,
  output logic [63:0] load_buffer,
  output logic        load_done,
  output logic        store_opn,
  output logic        reqcyc,
  output logic [63:0] req,
  output logic [15:0] reqtag,
  input  logic        reqack,
  input  logic        respcyc,
  input  logic [63:0] resp,
  output logic        respack
);

  localparam logic [15:0] TagRead  = 16'h8100;
  localparam logic [15:0] TagWrite = 16'h0100;

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StRdDone, StWrAddr, StWrData, StWrDone
  } state_e;

  state_e      r_state;
  logic [2:0]  r_beat;
  logic [63:3] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_load_buffer;
  logic        r_load_done;
  logic        r_store_opn;
  logic        r_reqcyc;
  logic [63:0] r_req;
  logic [15:0] r_reqtag;

  // Accesses are 8-byte aligned; the byte offset is deliberately dropped.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{data_reqAddr[2:0], store_reqAddr[2:0]};

`ifdef DMEM_LINE_BUFFER_EN
  logic [63:0] r_line [8];
  logic [63:6] r_lb_tag;
  logic        r_lb_valid;
  logic        r_hit;
  logic        w_ld_hit;
  logic        w_st_hit;

  assign w_ld_hit = r_lb_valid && (data_reqAddr[63:6] == r_lb_tag);
  assign w_st_hit = r_lb_valid && (r_addr[63:6] == r_lb_tag);

  // Line storage: filled beat by beat on a bus read, patched by stores that hit it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == StRdWait && respcyc) begin
        r_line[r_beat] <= resp;
      end else if (r_state == StWrDone && w_st_hit) begin
        r_line[r_addr[5:3]] <= r_wdata;
      end
    end
  end
`endif

  // Main controller: state plus every registered bus/handshake output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_beat        <= 3'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_load_buffer <= '0;
      r_load_done   <= 1'b0;
      r_store_opn   <= 1'b0;
      r_reqcyc      <= 1'b0;
      r_req         <= '0;
      r_reqtag      <= '0;
`ifdef DMEM_LINE_BUFFER_EN
      r_lb_tag      <= '0;
      r_lb_valid    <= 1'b0;
      r_hit         <= 1'b0;
`endif
    end else begin
      r_load_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Load has priority when both levels are high.
          if (data_reqFlag) begin
            r_addr   <= data_reqAddr[63:3];
            r_req    <= {data_reqAddr[63:6], 6'b0};
            r_reqtag <= TagRead;
            r_state  <= StRdReq;
`ifdef DMEM_LINE_BUFFER_EN
            r_hit    <= w_ld_hit;
            r_reqcyc <= !w_ld_hit;
            // A bus refill overwrites the line, so the old contents stop being valid.
            if (!w_ld_hit) r_lb_valid <= 1'b0;
`else
            r_reqcyc <= 1'b1;
`endif
          end else if (store_reqFlag) begin
            r_addr      <= store_reqAddr[63:3];
            r_wdata     <= store_data;
            r_reqcyc    <= 1'b1;
            r_req       <= {store_reqAddr[63:3], 3'b0};
            r_reqtag    <= TagWrite;
            r_store_opn <= 1'b1;
            r_state     <= StWrAddr;
          end
        end
        StRdReq: begin
`ifdef DMEM_LINE_BUFFER_EN
          if (r_hit) begin
            r_load_buffer <= r_line[r_addr[5:3]];
            r_load_done   <= 1'b1;
            r_state       <= StRdDone;
          end else
`endif
          if (reqack) begin
            r_reqcyc <= 1'b0;
            r_req    <= '0;
            r_reqtag <= '0;
            r_beat   <= 3'd0;
            r_state  <= StRdWait;
          end
        end
        StRdWait: begin
          if (respcyc) begin
            if (r_beat == r_addr[5:3]) r_load_buffer <= resp;
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) begin
              r_load_done <= 1'b1;
              r_state     <= StRdDone;
`ifdef DMEM_LINE_BUFFER_EN
              r_lb_valid  <= 1'b1;
              r_lb_tag    <= r_addr[63:6];
`endif
            end
          end
        end
        StRdDone: begin
          r_state <= StIdle;
        end
        StWrAddr: begin
          if (reqack) begin
            r_req   <= r_wdata;
            r_state <= StWrData;
          end
        end
        StWrData: begin
          if (reqack) begin
            r_reqcyc <= 1'b0;
            r_req    <= '0;
            r_reqtag <= '0;
            r_state  <= StWrDone;
          end
        end
        StWrDone: begin
          r_store_opn <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign load_buffer = r_load_buffer;
  assign load_done   = r_load_done;
  assign store_opn   = r_store_opn;
  assign reqcyc      = r_reqcyc;
  assign req         = r_req;
  assign reqtag      = r_reqtag;
  // Response beats are only consumed while collecting a line.
  assign respack     = !reset && (r_state == StRdWait) && respcyc;

endmodule

// File: tb/tb_mod_dmem_responder.sv
// Directed testbench for mod_dmem_responder with a small cycle-driven bus model.
module tb_mod_dmem_responder;

  logic        clk;
  logic        reset;
  logic        data_reqFlag;
  logic [63:0] data_reqAddr;
  logic        store_reqFlag;
  logic [63:0] store_reqAddr;
  logic [63:0] store_data;
  logic [63:0] load_buffer;
  logic        load_done;
  logic        store_opn;
  logic        reqcyc;
  logic [63:0] req;
  logic [15:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic        respack;

  int checks = 0;
  int errors = 0;

  // Observations recorded by the load driver.
  int          ld_done_cyc, ld_done_cnt, ld_respack_cnt, ld_respack_bad;
  int          ld_reqcyc_cnt, ld_unstable, ld_store_seen;
  logic [63:0] ld_req;
  logic [15:0] ld_tag;

  // Observations recorded by the store driver.
  int          st_beats, st_opn_cyc, st_first_cyc;
  logic [63:0] st_req [2];
  logic [15:0] st_tag [2];

  mod_dmem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .data_reqFlag  (data_reqFlag),
    .data_reqAddr  (data_reqAddr),
    .store_reqFlag (store_reqFlag),
    .store_reqAddr (store_reqAddr),
    .store_data    (store_data),
    .load_buffer   (load_buffer),
    .load_done     (load_done),
    .store_opn     (store_opn),
    .reqcyc        (reqcyc),
    .req           (req),
    .reqtag        (reqtag),
    .reqack        (reqack),
    .respcyc       (respcyc),
    .resp          (resp),
    .respack       (respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one load and plays the bus: acks after ack_dly request cycles, then sends
  // 8 beats base|i with gap idle cycles before each. Cycle 1 is the first cycle after
  // the request is sampled.
  task automatic do_load(input logic [63:0] addr, input logic [63:0] base, input int ack_dly,
                         input int gap, input logic with_store, input logic [63:0] s_addr,
                         input logic [63:0] s_data);
    int   cyc, stall, gcnt, beats;
    logic acked, seen;
    ld_done_cyc = -1; ld_done_cnt = 0; ld_respack_cnt = 0; ld_respack_bad = 0;
    ld_reqcyc_cnt = 0; ld_unstable = 0; ld_store_seen = 0; ld_req = '0; ld_tag = '0;
    cyc = 0; stall = 0; gcnt = 0; beats = 0; acked = 1'b0; seen = 1'b0;
    @(negedge clk);
    reqack = 1'b0; respcyc = 1'b0;
    data_reqFlag = 1'b1; data_reqAddr = addr;
    if (with_store) begin
      store_reqFlag = 1'b1; store_reqAddr = s_addr; store_data = s_data;
    end
    while (cyc < 60 && (ld_done_cyc < 0 || cyc < ld_done_cyc + 2)) begin
      @(negedge clk);
      cyc++;
      reqack = 1'b0; respcyc = 1'b0; resp = '0;
      if (reqcyc && !acked) begin
        ld_reqcyc_cnt++;
        if (!seen) begin
          ld_req = req; ld_tag = reqtag; seen = 1'b1;
        end else if (req !== ld_req || reqtag !== ld_tag) begin
          ld_unstable++;
        end
        if (stall >= ack_dly) begin
          reqack = 1'b1; acked = 1'b1;
        end else begin
          stall++;
        end
      end else if (acked && beats < 8) begin
        if (gcnt >= gap) begin
          respcyc = 1'b1; resp = base | 64'(beats); beats++; gcnt = 0;
        end else begin
          gcnt++;
        end
      end
      if (store_opn && ld_done_cyc < 0) ld_store_seen++;
      #1;
      if (respack) ld_respack_cnt++;
      if (respack !== respcyc) ld_respack_bad++;
      if (load_done) begin
        ld_done_cnt++;
        if (ld_done_cyc < 0) ld_done_cyc = cyc;
        data_reqFlag = 1'b0;
      end
    end
    reqack = 1'b0; respcyc = 1'b0;
  endtask

  // Issues one store, acks every write beat immediately, releases the level when
  // store_opn falls.
  task automatic do_store(input logic [63:0] addr, input logic [63:0] data);
    int   cyc;
    logic prev_opn, fell;
    st_beats = 0; st_opn_cyc = 0; st_first_cyc = -1;
    st_req[0] = '0; st_req[1] = '0; st_tag[0] = '0; st_tag[1] = '0;
    cyc = 0; prev_opn = 1'b0; fell = 1'b0;
    @(negedge clk);
    reqack = 1'b0; respcyc = 1'b0;
    store_reqFlag = 1'b1; store_reqAddr = addr; store_data = data;
    while (cyc < 40 && !fell) begin
      @(negedge clk);
      cyc++;
      reqack = 1'b0;
      if (reqcyc) begin
        if (st_first_cyc < 0) st_first_cyc = cyc;
        if (st_beats < 2) begin
          st_req[st_beats] = req; st_tag[st_beats] = reqtag;
        end
        st_beats++;
        reqack = 1'b1;
      end
      if (store_opn) st_opn_cyc++;
      if (prev_opn && !store_opn) begin
        fell = 1'b1; store_reqFlag = 1'b0;
      end
      prev_opn = store_opn;
    end
    reqack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; respcyc = 1'b1; resp = 64'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({reqcyc, load_done, store_opn, respack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {reqcyc, load_done, store_opn, respack});
    end
    checks++;
    if (req !== 64'h0 || reqtag !== 16'h0) begin
      errors++; $display("FAIL reset_req: got %h/%h expected 0/0", req, reqtag);
    end
    checks++;
    if (load_buffer !== 64'h0) begin
      errors++; $display("FAIL reset_load_buffer: got %h expected 0", load_buffer);
    end
    reset = 1'b0; respcyc = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (respack !== 1'b0 || reqcyc !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b%b expected 00", respack, reqcyc);
    end
  endtask

  task automatic test_load_nostall();
    do_load(64'h1018, 64'hA5A5_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_req !== 64'h1000 || ld_tag !== 16'h8100) begin
      errors++; $display("FAIL load_req: got %h/%h expected 1000/8100", ld_req, ld_tag);
    end
    checks++;
    if (load_buffer !== 64'hA5A5_0000_0000_0003) begin
      errors++; $display("FAIL load_data: got %h expected a5a5000000000003", load_buffer);
    end
    checks++;
    if (ld_done_cyc != 10 || ld_done_cnt != 1) begin
      errors++;
      $display("FAIL load_latency: got cyc %0d cnt %0d expected 10/1", ld_done_cyc, ld_done_cnt);
    end
    checks++;
    if (ld_respack_cnt != 8 || ld_respack_bad != 0) begin
      errors++;
      $display("FAIL load_respack: got %0d acks %0d bad expected 8/0", ld_respack_cnt,
               ld_respack_bad);
    end
  endtask

  task automatic test_stalls();
    do_load(64'h1FF8, 64'h5A5A_0000_0000_0000, 4, 2, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_req !== 64'h1FC0 || ld_unstable != 0 || ld_reqcyc_cnt != 5) begin
      errors++;
      $display("FAIL stall_req: got %h unstable %0d cycles %0d expected 1fc0/0/5", ld_req,
               ld_unstable, ld_reqcyc_cnt);
    end
    checks++;
    if (ld_respack_cnt != 8 || ld_respack_bad != 0) begin
      errors++;
      $display("FAIL stall_respack: got %0d acks %0d bad expected 8/0", ld_respack_cnt,
               ld_respack_bad);
    end
    checks++;
    if (ld_done_cnt != 1 || ld_done_cyc != 30) begin
      errors++;
      $display("FAIL stall_done: got cnt %0d cyc %0d expected 1/30", ld_done_cnt, ld_done_cyc);
    end
    checks++;
    if (load_buffer !== 64'h5A5A_0000_0000_0007) begin
      errors++; $display("FAIL stall_data: got %h expected 5a5a000000000007", load_buffer);
    end
  endtask

  task automatic test_store();
    do_store(64'h2004, 64'hDEADBEEF);
    checks++;
    if (st_req[0] !== 64'h2000 || st_tag[0] !== 16'h0100) begin
      errors++; $display("FAIL store_addr_beat: got %h/%h expected 2000/0100", st_req[0],
                         st_tag[0]);
    end
    checks++;
    if (st_req[1] !== 64'hDEADBEEF || st_beats != 2) begin
      errors++; $display("FAIL store_data_beat: got %h beats %0d expected deadbeef/2", st_req[1],
                         st_beats);
    end
    checks++;
    if (st_opn_cyc != 3 || st_first_cyc != 1) begin
      errors++; $display("FAIL store_opn: got %0d cycles first %0d expected 3/1", st_opn_cyc,
                         st_first_cyc);
    end
    checks++;
    if (load_buffer !== 64'h5A5A_0000_0000_0007) begin
      errors++; $display("FAIL store_keeps_load_buffer: got %h expected 5a5a000000000007",
                         load_buffer);
    end
  endtask

  task automatic test_simultaneous();
    do_load(64'h3000, 64'h3333_0000_0000_0000, 0, 0, 1'b1, 64'h3040, 64'h1234_5678_9ABC_DEF0);
    checks++;
    if (ld_tag !== 16'h8100 || ld_req !== 64'h3000 || ld_store_seen != 0) begin
      errors++; $display("FAIL simul_load_first: got %h/%h store %0d expected 8100/3000/0",
                         ld_tag, ld_req, ld_store_seen);
    end
    checks++;
    if (ld_done_cyc != 10 || load_buffer !== 64'h3333_0000_0000_0000) begin
      errors++; $display("FAIL simul_load_done: got cyc %0d data %h expected 10/3333000000000000",
                         ld_done_cyc, load_buffer);
    end
    do_store(64'h3040, 64'h1234_5678_9ABC_DEF0);
    checks++;
    if (st_req[0] !== 64'h3040 || st_tag[0] !== 16'h0100 ||
        st_req[1] !== 64'h1234_5678_9ABC_DEF0 || st_beats != 2) begin
      errors++; $display("FAIL simul_store: got %h/%h/%h beats %0d expected 3040/0100/data/2",
                         st_req[0], st_tag[0], st_req[1], st_beats);
    end
  endtask

  task automatic test_reset_midread();
    logic found;
    int   late_ack, done_seen;
    found = 1'b0; late_ack = 0; done_seen = 0;
    @(negedge clk);
    data_reqFlag = 1'b1; data_reqAddr = 64'h4008;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (reqcyc) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_req_seen: got no reqcyc expected reqcyc");
    end
    reqack = 1'b1;
    @(negedge clk);
    reqack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      respcyc = 1'b1; resp = 64'h4444_0000_0000_0000 | 64'(b);
      if (b == 4) begin
        reset = 1'b1; data_reqFlag = 1'b0;
      end
      if (b == 5) begin
        reset = 1'b0;
        #1;
        checks++;
        if ({reqcyc, load_done, store_opn, respack} !== 4'b0 || req !== 64'h0 ||
            reqtag !== 16'h0) begin
          errors++; $display("FAIL abort_outputs: got %b %h %h expected 0000 0 0",
                             {reqcyc, load_done, store_opn, respack}, req, reqtag);
        end
        checks++;
        if (load_buffer !== 64'h0) begin
          errors++; $display("FAIL abort_load_buffer: got %h expected 0", load_buffer);
        end
      end
      #1;
      if (b >= 5 && respack) late_ack++;
      if (load_done) done_seen++;
      @(negedge clk);
    end
    respcyc = 1'b0;
    repeat (3) begin
      #1;
      if (load_done) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (late_ack != 0 || done_seen != 0) begin
      errors++; $display("FAIL abort_beats: got %0d acks %0d done expected 0/0", late_ack,
                         done_seen);
    end
  endtask

`ifdef DMEM_LINE_BUFFER_EN
  task automatic test_line_buffer();
    do_load(64'h1018, 64'h6666_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_reqcyc_cnt != 1 || load_buffer !== 64'h6666_0000_0000_0003) begin
      errors++; $display("FAIL lb_fill: got %0d req %h expected 1/6666000000000003",
                         ld_reqcyc_cnt, load_buffer);
    end
    do_load(64'h1020, 64'h7777_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_reqcyc_cnt != 0 || ld_done_cyc != 2 || load_buffer !== 64'h6666_0000_0000_0004) begin
      errors++; $display("FAIL lb_hit: got %0d req cyc %0d data %h expected 0/2/6666000000000004",
                         ld_reqcyc_cnt, ld_done_cyc, load_buffer);
    end
    do_store(64'h1028, 64'hCAFE_F00D_0000_0055);
    do_load(64'h1028, 64'h7777_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_reqcyc_cnt != 0 || load_buffer !== 64'hCAFE_F00D_0000_0055) begin
      errors++; $display("FAIL lb_store_update: got %0d req data %h expected 0/cafef00d00000055",
                         ld_reqcyc_cnt, load_buffer);
    end
  endtask
`else
  task automatic test_line_buffer();
    do_load(64'h1018, 64'h6666_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    do_load(64'h1020, 64'h7777_0000_0000_0000, 0, 0, 1'b0, 64'h0, 64'h0);
    checks++;
    if (ld_reqcyc_cnt != 1 || ld_done_cyc != 10 || load_buffer !== 64'h7777_0000_0000_0004) begin
      errors++; $display("FAIL no_lb_bus: got %0d req cyc %0d data %h expected 1/10/7777000000000004",
                         ld_reqcyc_cnt, ld_done_cyc, load_buffer);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; data_reqFlag = 1'b0; data_reqAddr = '0; store_reqFlag = 1'b0;
    store_reqAddr = '0; store_data = '0; reqack = 1'b0; respcyc = 1'b0; resp = '0;
    test_reset();
    test_load_nostall();
    test_stalls();
    test_store();
    test_simultaneous();
    test_reset_midread();
    test_line_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
